// File: rtl/lsu_sram_sequencer_if.sv
// LSU-side request/response bundle for the external SRAM sequencer.
// The requester holds addr/data/control and a wren or rden level until ack.
interface lsu_sram_sequencer_if;
  logic [15:0] addr;
  logic [31:0] st_data;
  logic        wren;
  logic        rden;
  logic [2:0]  control;
  logic [31:0] sram_data;
  logic        ack;
  logic        busy;

  modport master (
    output addr, st_data, wren, rden, control,
    input  sram_data, ack, busy
  );

  modport slave (
    input  addr, st_data, wren, rden, control,
    output sram_data, ack, busy
  );
endinterface

// File: rtl/lsu_sram_sequencer.sv
// Splits 32-bit LSU loads/stores in the SRAM window into one or two halfword cycles
// on a 16-bit asynchronous SRAM. ACCESS_CYCLES must be at least 2.
module lsu_sram_sequencer #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [15:0] SRAM_BASE     = 16'h2000,
  parameter logic [15:0] SRAM_LAST     = 16'h3FFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lsu_sram_sequencer_if.slave  lsu,
  output logic [17:0]          SRAM_ADDR,
  inout  wire  [15:0]          SRAM_DQ,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_UB_N
);

  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    ACK   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        word_q, byte_q, lane_q, uns_q;
  logic [14:0] hw_addr_q;
  logic [31:0] st_data_q;
  logic [15:0] cap_lo_q;
  logic [31:0] rdata_q;

  logic        dq_oe;
  logic        ack;
  logic [15:0] wr_half;

  // Sign or zero extension of the final halfword; words simply concatenate.
  function automatic logic [31:0] load_extend(input logic [15:0] dq_hi,
                                              input logic [15:0] dq_lo,
                                              input logic        word,
                                              input logic        byte_acc,
                                              input logic        lane,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = lane ? dq_hi[15:8] : dq_hi[7:0];
    h = dq_hi;
    if (word)
      r = {dq_hi, dq_lo};
    else if (byte_acc)
      r = uns ? {24'd0, b} : 32'(b);
    else
      r = uns ? {16'd0, h} : 32'(h);
    return r;
  endfunction

  // Byte stores replicate onto both lanes; LB_N/UB_N pick the one that lands.
  function automatic logic [15:0] write_half(input logic [31:0] st,
                                             input logic        hi,
                                             input logic        byte_acc);
    logic [15:0] r;
    if (byte_acc)
      r = {st[7:0], st[7:0]};
    else if (hi)
      r = st[31:16];
    else
      r = st[15:0];
    return r;
  endfunction

  logic in_window, req, accept, in_word, in_byte, last, lo_done, rd_final;

  assign in_window = (lsu.addr >= SRAM_BASE) && (lsu.addr <= SRAM_LAST);
  assign req       = (lsu.rden | lsu.wren) && in_window;
  assign accept    = (state_q == IDLE) && req;
  assign in_byte   = (lsu.control[1:0] == 2'b00);
  assign in_word   = lsu.control[1];
  assign last      = (cnt_q == CNT_LAST);
  assign lo_done   = ((state_q == RD_LO) || (state_q == WR_LO)) && last;
  assign rd_final  = last && ((state_q == RD_HI) || ((state_q == RD_LO) && !word_q));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_UB_N = 1'b1;
    dq_oe     = 1'b0;
    ack       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req)
          state_d = lsu.wren ? WR_LO : RD_LO;
      end
      RD_LO, RD_HI, WR_LO, WR_HI: begin
        SRAM_CE_N = 1'b0;
        SRAM_LB_N = byte_q & lane_q;
        SRAM_UB_N = byte_q & ~lane_q;
        if ((state_q == WR_LO) || (state_q == WR_HI)) begin
          dq_oe     = 1'b1;
          // WE_N rises one clock early so data is held past the write edge.
          SRAM_WE_N = last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (last) begin
          cnt_d = '0;
          if ((state_q == RD_LO) && word_q)
            state_d = RD_HI;
          else if ((state_q == WR_LO) && word_q)
            state_d = WR_HI;
          else
            state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q    <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= 1'b0;
      uns_q     <= 1'b0;
      hw_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        word_q    <= in_word;
        byte_q    <= in_byte;
        lane_q    <= lsu.addr[0];
        uns_q     <= lsu.control[2];
        hw_addr_q <= in_word ? {lsu.addr[15:2], 1'b0} : lsu.addr[15:1];
      end else if (lo_done && word_q) begin
        hw_addr_q <= {hw_addr_q[14:1], 1'b1};
      end
      if (rd_final)
        rdata_q <= load_extend(SRAM_DQ, cap_lo_q, word_q, byte_q, lane_q, uns_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept)
      st_data_q <= lsu.st_data;
    if ((state_q == RD_LO) && last)
      cap_lo_q <= SRAM_DQ;
  end

  assign wr_half       = write_half(st_data_q, state_q == WR_HI, byte_q);
  assign SRAM_DQ       = dq_oe ? wr_half : 16'bz;
  assign SRAM_ADDR     = {3'b000, hw_addr_q};
  assign lsu.ack       = ack;
  assign lsu.busy      = (state_q != IDLE);
  assign lsu.sram_data = rdata_q;

endmodule
